// File: rtl/sample_buffer_trig.sv
// Banked logic-analyzer capture buffer: sliding pre-trigger window, qualified
// post-trigger capture, and a 2-entry valid/ready readout queue over 1-cycle RAM banks.
module sample_buffer_trig #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned BANK_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              clear,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              trigger,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic [ADDR_W:0]   posttrig_len,
  input  logic              rd_start,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned BADDR_W = ADDR_W - BANK_W;
  localparam int unsigned NBANK   = 2 ** BANK_W;
  localparam int unsigned BDEPTH  = 2 ** BADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_POST = 3'd2,
    S_DONE = 3'd3,
    S_READ = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]   p_len_q, p_len_d;
  logic [PTR_W-1:0]    t_len_q, t_len_d;
  logic [PTR_W-1:0]    unread_q, unread_d;
  logic                rd_vld_q, rd_vld_d;
  logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
  logic [1:0]          q_cnt_q, q_cnt_d;
  logic [DATA_W-1:0]   q0_q, q0_d;
  logic [DATA_W-1:0]   q1_q, q1_d;
  logic                dout_valid_q, dout_valid_d;
  logic                dout_last_q, dout_last_d;

  logic                wr_en_c, rd_en_c, pop_c;
  logic [BANK_W-1:0]   wr_bank_c, rd_bank_c;
  logic [BADDR_W-1:0]  wr_addr_c, rd_addr_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic [DATA_W-1:0]   bank_rdata [NBANK];

  function automatic logic is_full(input logic [PTR_W-1:0] w, input logic [PTR_W-1:0] r);
    return (w[ADDR_W-1:0] == r[ADDR_W-1:0]) && (w[ADDR_W] != r[ADDR_W]);
  endfunction

  assign wr_bank_c = wr_ptr_q[ADDR_W-1 -: BANK_W];
  assign wr_addr_c = wr_ptr_q[BADDR_W-1:0];
  assign rd_bank_c = rd_ptr_q[ADDR_W-1 -: BANK_W];
  assign rd_addr_c = rd_ptr_q[BADDR_W-1:0];
  assign rd_data_c = bank_rdata[rd_bank_q];
  assign pop_c     = dout_valid_q & dout_ready;

  // One RAM bank per slice of the pointer; only the addressed bank is enabled.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DATA_W-1:0] mem [BDEPTH];
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (wr_en_c && (wr_bank_c == BANK_W'(b))) mem[wr_addr_c] <= sample_in;
      if (rd_en_c && (rd_bank_c == BANK_W'(b))) rdata_q <= mem[rd_addr_c];
    end
    assign bank_rdata[b] = rdata_q;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    p_len_d    = p_len_q;
    t_len_d    = t_len_q;
    unread_d   = unread_q;
    rd_bank_d  = rd_bank_q;
    rd_vld_d   = 1'b0;
    q_cnt_d    = q_cnt_q;
    q0_d       = q0_q;
    q1_d       = q1_q;
    wr_en_c    = 1'b0;
    rd_en_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_PRE;
          p_len_d = pretrig_len;
          t_len_d = (posttrig_len == '0) ? PTR_W'(1) : posttrig_len;
        end
      end
      S_PRE: begin
        if (sample_en) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (count_q < PTR_W'(p_len_q)) begin
            count_d = count_q + PTR_W'(1);
          end else if (trigger) begin
            count_d    = count_q + PTR_W'(1);
            post_cnt_d = PTR_W'(1);
            state_d    = ((t_len_q == PTR_W'(1)) || is_full(wr_ptr_d, rd_ptr_q)) ? S_DONE : S_POST;
          end else begin
            // window already holds P samples: slide it, dropping the oldest
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      S_POST: begin
        if (sample_en) begin
          wr_en_c    = 1'b1;
          wr_ptr_d   = wr_ptr_q + PTR_W'(1);
          count_d    = count_q + PTR_W'(1);
          post_cnt_d = post_cnt_q + PTR_W'(1);
          if ((post_cnt_d == t_len_q) || is_full(wr_ptr_d, rd_ptr_q)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rd_start) begin
          state_d  = S_READ;
          unread_d = count_q;
        end
      end
      S_READ: begin
        // a beat accepted this cycle frees its slot, sustaining 1 beat/clk
        if ((unread_q != '0) &&
            ((3'(q_cnt_q) + 3'(rd_vld_q)) < (3'd2 + 3'(pop_c)))) begin
          rd_en_c   = 1'b1;
          rd_vld_d  = 1'b1;
          rd_bank_d = rd_bank_c;
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          unread_d  = unread_q - PTR_W'(1);
        end
        if (pop_c) begin
          count_d = count_q - PTR_W'(1);
          if (count_q == PTR_W'(1)) begin
            state_d    = S_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            post_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output queue: slot 0 drives dout, slot 1 absorbs a return during a stall.
    unique case (q_cnt_q)
      2'd0: begin
        if (rd_vld_q) begin
          q0_d    = rd_data_c;
          q_cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (rd_vld_q && pop_c) begin
          q0_d = rd_data_c;
        end else if (rd_vld_q) begin
          q1_d    = rd_data_c;
          q_cnt_d = 2'd2;
        end else if (pop_c) begin
          q_cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop_c) begin
          q0_d    = q1_q;
          q_cnt_d = 2'd1;
        end
      end
    endcase

    if (clear) begin
      state_d    = S_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      p_len_d    = '0;
      t_len_d    = '0;
      unread_d   = '0;
      rd_bank_d  = '0;
      rd_vld_d   = 1'b0;
      q_cnt_d    = 2'd0;
      q0_d       = '0;
      q1_d       = '0;
    end
    if (clear || reset) begin
      wr_en_c = 1'b0;
      rd_en_c = 1'b0;
    end

    dout_valid_d = (q_cnt_d != 2'd0);
    dout_last_d  = (q_cnt_d != 2'd0) && (count_d == PTR_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      post_cnt_q   <= '0;
      p_len_q      <= '0;
      t_len_q      <= '0;
      unread_q     <= '0;
      rd_vld_q     <= 1'b0;
      rd_bank_q    <= '0;
      q_cnt_q      <= 2'd0;
      q0_q         <= '0;
      q1_q         <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      post_cnt_q   <= post_cnt_d;
      p_len_q      <= p_len_d;
      t_len_q      <= t_len_d;
      unread_q     <= unread_d;
      rd_vld_q     <= rd_vld_d;
      rd_bank_q    <= rd_bank_d;
      q_cnt_q      <= q_cnt_d;
      q0_q         <= q0_d;
      q1_q         <= q1_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
    end
  end

  assign dout       = q0_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign state      = state_q;
  assign count      = count_q;

endmodule

// File: tb/tb_sample_buffer_trig.sv
// Bench for sample_buffer_trig (DEPTH=16, 4 banks): directed scenarios plus random
// captures, checked against a queue-based model of the capture window.
module tb_sample_buffer_trig;

  logic       clk = 1'b0;
  logic       reset, arm, clear, sample_en, trigger, rd_start, dout_ready;
  logic [7:0] sample_in, dout;
  logic [3:0] pretrig_len;
  logic [4:0] posttrig_len;
  logic       dout_valid, dout_last;
  logic [2:0] state;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  // Reference model: the retained samples in arrival order.
  logic [7:0] m_q[$];
  int         m_phase;   // 0 idle, 1 pre, 2 post, 3 done
  int         m_P, m_T, m_post;

  logic [7:0] got[$];
  bit         lasts[$];
  int         stall_err, first_lat, last_c;
  bit         timed_out;
  int         pat[6] = '{1, 0, 0, 1, 0, 1};

  sample_buffer_trig #(.DATA_W(8), .ADDR_W(4), .BANK_W(2)) dut (
    .clk(clk), .reset(reset), .arm(arm), .clear(clear), .sample_en(sample_en),
    .sample_in(sample_in), .trigger(trigger), .pretrig_len(pretrig_len),
    .posttrig_len(posttrig_len), .rd_start(rd_start), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .state(state), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_arm(input int p, input int t);
    m_q.delete();
    m_P     = (p > 15) ? 15 : p;
    m_T     = (t == 0) ? 1 : t;
    m_post  = 0;
    m_phase = 1;
  endfunction

  function automatic void model_sample(input logic [7:0] d, input bit trg);
    if (m_phase == 1) begin
      if (trg && (m_q.size() == m_P)) begin
        m_q.push_back(d);
        m_post  = 1;
        m_phase = ((m_post >= m_T) || (m_q.size() == 16)) ? 3 : 2;
      end else begin
        m_q.push_back(d);
        if (m_q.size() > m_P) void'(m_q.pop_front());
      end
    end else if (m_phase == 2) begin
      m_q.push_back(d);
      m_post++;
      if ((m_post >= m_T) || (m_q.size() == 16)) m_phase = 3;
    end
  endfunction

  function automatic int stream_diff();
    if (got.size() != m_q.size()) return (got.size() < m_q.size()) ? got.size() : m_q.size();
    foreach (got[k]) begin
      if ((got[k] !== m_q[k]) || (lasts[k] != (k == got.size() - 1))) return k;
    end
    return -1;
  endfunction

  task automatic pulse_arm(input int p, input int t);
    pretrig_len  = 4'(p);
    posttrig_len = 5'(t);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_arm(input int p, input int t);
    pulse_arm(p, t);
    model_arm(p, t);
  endtask

  task automatic send(input logic [7:0] d, input bit trg);
    sample_en = 1'b1;
    sample_in = d;
    trigger   = trg;
    model_sample(d, trg);
    tick();
    sample_en = 1'b0;
    trigger   = 1'b0;
  endtask

  // Runs a readout under a ready pattern (0 always, 1 fixed, 2 random) and records beats.
  task automatic collect(input int mode);
    logic [7:0] pd;
    logic       pl;
    bit         prev_stall, done, rdy;
    got.delete();
    lasts.delete();
    stall_err = 0; first_lat = -1; last_c = -1; done = 1'b0; prev_stall = 1'b0;
    pd = '0; pl = 1'b0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (pat[c % 6] != 0);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      dout_ready = rdy;
      if (prev_stall && ((dout_valid !== 1'b1) || (dout !== pd) || (dout_last !== pl))) stall_err++;
      if ((dout_valid === 1'b1) && (first_lat < 0)) first_lat = c;
      if ((dout_valid === 1'b1) && rdy) begin
        got.push_back(dout);
        lasts.push_back(dout_last === 1'b1);
        if (dout_last === 1'b1) begin
          done   = 1'b1;
          last_c = c;
        end
      end
      prev_stall = (dout_valid === 1'b1) && !rdy;
      pd = dout;
      pl = dout_last;
      tick();
    end
    dout_ready = 1'b0;
    timed_out  = !done;
    m_phase    = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ((dout_valid !== 1'b0) || (dout_last !== 1'b0) || (dout !== 8'd0)) begin
      errors++; $display("FAIL reset_outputs valid=%b last=%b dout=%0h exp 0/0/0", dout_valid, dout_last, dout);
    end
    send(8'h55, 1'b1);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    checks++; if ((state !== 3'd0) || (count !== 5'd0) || (dout_valid !== 1'b0)) begin
      errors++; $display("FAIL idle_ignores state=%0d count=%0d valid=%b exp 0/0/0", state, count, dout_valid);
    end
  endtask

  task automatic test_ramp();
    int d;
    do_arm(4, 6);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL ramp_arm state=%0d exp=1", state); end
    for (int i = 0; i < 20 && m_phase != 3; i++) begin
      send(8'(i), i == 10);
      checks++; if (state !== 3'(m_phase)) begin errors++; $display("FAIL ramp_state i=%0d got=%0d exp=%0d", i, state, m_phase); end
    end
    checks++; if (count !== 5'd10) begin errors++; $display("FAIL ramp_done_count got=%0d exp=10", count); end
    pulse_arm(1, 1);
    send(8'hAA, 1'b1);
    checks++; if ((state !== 3'd3) || (count !== 5'd10)) begin
      errors++; $display("FAIL done_ignores state=%0d count=%0d exp 3/10", state, count);
    end
    collect(0);
    d = stream_diff();
    checks++; if (timed_out || d != -1) begin errors++; $display("FAIL ramp_stream idx=%0d got_n=%0d exp_n=%0d timeout=%0b", d, got.size(), m_q.size(), timed_out); end
    checks++; if ((got.size() == 0) || (got[0] !== 8'd6) || (got[got.size()-1] !== 8'd15)) begin
      errors++; $display("FAIL ramp_ends n=%0d exp first 6 last 15", got.size());
    end
    checks++; if (first_lat != 2) begin errors++; $display("FAIL ramp_latency got=%0d exp=2", first_lat); end
    checks++; if ((last_c - first_lat + 1) != 10) begin errors++; $display("FAIL ramp_throughput span=%0d exp=10", last_c - first_lat + 1); end
    checks++; if ((state !== 3'd0) || (count !== 5'd0)) begin errors++; $display("FAIL ramp_end state=%0d count=%0d exp 0/0", state, count); end
  endtask

  task automatic test_trigger_qualify();
    int d;
    do_arm(4, 3);
    for (int i = 0; i < 20 && m_phase != 3; i++) begin
      send(8'(i), (i == 2) || (i == 7));
      checks++; if (state !== 3'(m_phase)) begin errors++; $display("FAIL qual_state i=%0d got=%0d exp=%0d", i, state, m_phase); end
    end
    collect(0);
    d = stream_diff();
    checks++; if (timed_out || d != -1) begin errors++; $display("FAIL qual_stream idx=%0d got_n=%0d exp_n=%0d", d, got.size(), m_q.size()); end
    checks++; if ((got.size() < 5) || (got[0] !== 8'd3) || (got[4] !== 8'd7)) begin
      errors++; $display("FAIL qual_window n=%0d exp got[0]=3 got[4]=7", got.size());
    end
  endtask

  task automatic test_wrap();
    int d;
    do_arm(8, 20);
    for (int i = 0; i < 40 && m_phase != 3; i++) begin
      send(8'($urandom), i == 11);
      checks++; if (state !== 3'(m_phase)) begin errors++; $display("FAIL wrap_state i=%0d got=%0d exp=%0d", i, state, m_phase); end
    end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL wrap_full_count got=%0d exp=16", count); end
    collect(0);
    d = stream_diff();
    checks++; if (timed_out || d != -1) begin errors++; $display("FAIL wrap_stream idx=%0d got_n=%0d exp_n=%0d", d, got.size(), m_q.size()); end
  endtask

  task automatic test_stall();
    int d;
    do_arm(3, 9);
    for (int i = 0; i < 40 && m_phase != 3; i++) send(8'($urandom), i == 5);
    collect(1);
    d = stream_diff();
    checks++; if (timed_out || d != -1) begin errors++; $display("FAIL stall_stream idx=%0d got_n=%0d exp_n=%0d", d, got.size(), m_q.size()); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_hold changes=%0d exp=0", stall_err); end
  endtask

  task automatic test_clear();
    int d;
    do_arm(2, 8);
    for (int i = 0; i < 5; i++) send(8'(100 + i), i == 2);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL clear_pre state=%0d exp=2", state); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_phase = 0;
    checks++; if ((state !== 3'd0) || (count !== 5'd0) || (dout_valid !== 1'b0)) begin
      errors++; $display("FAIL clear_effect state=%0d count=%0d valid=%b exp 0/0/0", state, count, dout_valid);
    end
    do_arm(2, 2);
    for (int i = 0; i < 20 && m_phase != 3; i++) send(8'(20 + i), i == 3);
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL clear_rearm_count got=%0d exp=4", count); end
    collect(0);
    d = stream_diff();
    checks++; if (timed_out || d != -1) begin errors++; $display("FAIL clear_stream idx=%0d got_n=%0d exp_n=%0d", d, got.size(), m_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    do_arm(2, 3);
    for (int i = 0; i < 40 && m_phase != 3; i++) send(8'($urandom), i >= 2);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    dout_ready = 1'b0;
    for (int c = 0; c < 10 && dout_valid !== 1'b1; c++) tick();
    checks++; if ((dout_valid !== 1'b1) || (state !== 3'd4)) begin
      errors++; $display("FAIL midread_setup valid=%b state=%0d exp 1/4", dout_valid, state);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_phase = 0;
    checks++; if ((state !== 3'd0) || (dout_valid !== 1'b0) || (count !== 5'd0) || (dout_last !== 1'b0)) begin
      errors++; $display("FAIL midread_reset state=%0d valid=%b count=%0d last=%b exp 0/0/0/0", state, dout_valid, count, dout_last);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int p;
      int t;
      int d;
      p = (it == 0) ? 0 : (it == 1) ? 15 : int'($urandom_range(0, 15));
      t = (it == 0) ? 0 : (it == 1) ? 31 : int'($urandom_range(0, 20));
      do_arm(p, t);
      for (int n = 0; n < 150 && m_phase != 3; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          // unqualified trigger and stray arm/rd_start must change nothing
          trigger      = 1'b1;
          arm          = 1'($urandom_range(0, 1));
          rd_start     = 1'($urandom_range(0, 1));
          pretrig_len  = 4'($urandom);
          tick();
          trigger = 1'b0; arm = 1'b0; rd_start = 1'b0;
        end else begin
          send(8'($urandom), (n > 60) || ($urandom_range(0, 4) == 0));
        end
        checks++; if (state !== 3'(m_phase)) begin errors++; $display("FAIL rand_state it=%0d n=%0d got=%0d exp=%0d", it, n, state, m_phase); end
      end
      checks++; if (count !== 5'(m_q.size())) begin errors++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, count, m_q.size()); end
      collect(2);
      d = stream_diff();
      checks++; if (timed_out || d != -1) begin errors++; $display("FAIL rand_stream it=%0d idx=%0d got_n=%0d exp_n=%0d", it, d, got.size(), m_q.size()); end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL rand_hold it=%0d changes=%0d exp=0", it, stall_err); end
      checks++; if ((state !== 3'd0) || (count !== 5'd0)) begin errors++; $display("FAIL rand_end it=%0d state=%0d count=%0d exp 0/0", it, state, count); end
    end
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; clear = 1'b0; sample_en = 1'b0; sample_in = '0;
    trigger = 1'b0; rd_start = 1'b0; dout_ready = 1'b0; pretrig_len = '0; posttrig_len = '0;
    m_phase = 0; m_P = 0; m_T = 1; m_post = 0;
    test_reset();
    test_ramp();
    test_trigger_qualify();
    test_wrap();
    test_stall();
    test_clear();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
